// File: rtl/i2c_arbiter_pkg.sv
// ============================================================================
// Module      : i2c_arb_pkg (package)
// Description : Shared types and constants for the two-requester I2C
//               transaction arbiter: FSM state encoding, address/data widths
//               and requester count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int REQ_N  = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_arbiter_if.sv
// ============================================================================
// Module      : i2c_arbiter_if (interface)
// Description : Bundles the requester handshakes and the shared I2C master
//               command bus seen by the arbiter.
//   Requester side : req0/req1, addr0/addr1, d0_0/d0_1/d1_0/d1_1, ack0/ack1
//   Arbiter status : gnt (one-hot), err (sticky timeout)
//   I2C master side: i2c_start, i2c_address, i2c_data_0/1, i2c_busy
//   Modports       : master = arbiter view, slave = environment view
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_arbiter_if;
    import i2c_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] d0_0;
    logic [DATA_W-1:0] d0_1;
    logic [DATA_W-1:0] d1_0;
    logic [DATA_W-1:0] d1_1;
    logic              ack0;
    logic              ack1;
    logic [REQ_N-1:0]  gnt;
    logic              i2c_start;
    logic [ADDR_W-1:0] i2c_address;
    logic [DATA_W-1:0] i2c_data_0;
    logic [DATA_W-1:0] i2c_data_1;
    logic              i2c_busy;
    logic              err;

    modport master (
        input  req0, req1, addr0, addr1, d0_0, d0_1, d1_0, d1_1, i2c_busy,
        output ack0, ack1, gnt, i2c_start, i2c_address, i2c_data_0,
               i2c_data_1, err
    );

    modport slave (
        output req0, req1, addr0, addr1, d0_0, d0_1, d1_0, d1_1, i2c_busy,
        input  ack0, ack1, gnt, i2c_start, i2c_address, i2c_data_0,
               i2c_data_1, err
    );

endinterface

`default_nettype wire

// File: rtl/i2c_arbiter_rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin pick. The requester that was served last
//               gets the lower priority.
//   req[1:0]   : pending requests
//   last       : index of the requester served most recently
//   grant[1:0] : one-hot pick, 2'b00 when nothing is pending
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic      [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (last) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_arbiter.sv
// ============================================================================
// Module      : i2c_arbiter
// Description : Arbitrates two configuration queues onto one I2C master.
//               Grants round-robin, latches the winner's address/data, holds
//               i2c_start until the master reports busy, waits for busy to
//               fall, then pulses the winner's ack for one cycle.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : i2c_arbiter_if.master (requests, acks, grant, I2C command)
//   Parameter TIMEOUT_CYCLES : max cycles allowed in START or WAIT_DONE
//   Macro I2C_ARB_TIMEOUT_EN : enables the phase timeout counter and err;
//                              without it err is tied low and phases wait
//                              indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic   clk,
    input  wire logic   rst,
    i2c_arbiter_if.master bus
);

    state_t            r_state;
    state_t            w_next;
    logic [REQ_N-1:0]  w_req;
    logic [REQ_N-1:0]  w_pick;
    logic [REQ_N-1:0]  r_gnt;
    logic              r_last;       // 1 after reset, so requester 0 wins first
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_0;
    logic [DATA_W-1:0] r_data_1;
    logic              w_timeout;
    logic              w_to_fire;    // phase ended by timeout this cycle
    logic              w_err;

    assign w_req = {bus.req1, bus.req0};

    rr_pick2 u_pick (
        .req   (w_req),
        .last  (r_last),
        .grant (w_pick)
    );

    always_comb begin
        w_next    = r_state;
        w_to_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.i2c_busy && (w_req != '0)) w_next = ST_START;
            end
            ST_START: begin
                if (bus.i2c_busy) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_next    = ST_DONE;
                    w_to_fire = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.i2c_busy) begin
                    w_next = ST_DONE;
                end else if (w_timeout) begin
                    w_next    = ST_DONE;
                    w_to_fire = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_data_0 <= '0;
            r_data_1 <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && (w_next == ST_START)) begin
                r_gnt    <= w_pick;
                r_addr   <= w_pick[1] ? bus.addr1 : bus.addr0;
                r_data_0 <= w_pick[1] ? bus.d1_0  : bus.d0_0;
                r_data_1 <= w_pick[1] ? bus.d1_1  : bus.d0_1;
            end
            if (r_state == ST_DONE) begin
                r_gnt  <= '0;
                r_last <= r_gnt[1];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // r_cnt counts completed cycles in the current phase; the last allowed
    // cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign w_timeout = ((r_state == ST_START) || (r_state == ST_WAIT_DONE)) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_START) || (r_state == ST_WAIT_DONE)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_to_fire) r_err <= 1'b1;
        end
    end

    assign w_err = r_err;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_err        = 1'b0;
    assign w_unused_cfg = w_to_fire | (TIMEOUT_CYCLES != 0);
`endif

    assign bus.gnt         = r_gnt;
    assign bus.ack0        = (r_state == ST_DONE) && r_gnt[0];
    assign bus.ack1        = (r_state == ST_DONE) && r_gnt[1];
    assign bus.i2c_start   = (r_state == ST_START);
    assign bus.i2c_address = r_addr;
    assign bus.i2c_data_0  = r_data_0;
    assign bus.i2c_data_1  = r_data_1;
    assign bus.err         = w_err;

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Directed self-checking bench for i2c_arbiter. Inputs are
//               driven and outputs sampled on the falling clock edge.
//               Compile with I2C_ARB_TIMEOUT_EN to exercise the timeout path
//               (TIMEOUT_CYCLES=16); otherwise the indefinite-wait path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_arbiter;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    i2c_arbiter_if bus ();

    i2c_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    // Runs one transaction whose grant is already issued or imminent.
    // Scrambles the requester addresses while the master is busy and
    // restores them once DONE is reached.
    task automatic run_txn(input logic [1:0] exp_g, input logic [6:0] exp_a,
                           input logic [7:0] exp_d0, input int hold);
        int n;
        int a0;
        int a1;
        int bad;
        logic [6:0] sa0;
        logic [6:0] sa1;
        n = 0;
        while (!bus.i2c_start && n < 20) begin
            step;
            n++;
        end
        chk("txn_start", 32'(bus.i2c_start), 32'd1);
        chk("txn_gnt", 32'(bus.gnt), 32'(exp_g));
        chk("txn_addr", 32'(bus.i2c_address), 32'(exp_a));
        chk("txn_data0", 32'(bus.i2c_data_0), 32'(exp_d0));
        sa0 = bus.addr0;
        sa1 = bus.addr1;
        bus.i2c_busy = 1'b1;
        step;
        chk("txn_start_drop", 32'(bus.i2c_start), 32'd0);
        bus.addr0 = ~sa0;
        bus.addr1 = ~sa1;
        repeat (hold) step;
        chk("txn_addr_hold", 32'(bus.i2c_address), 32'(exp_a));
        bus.i2c_busy = 1'b0;
        a0 = 0;
        a1 = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step;
            if (i == 0) begin
                chk("txn_addr_done", 32'(bus.i2c_address), 32'(exp_a));
                bus.addr0 = sa0;
                bus.addr1 = sa1;
            end
            a0 += int'(bus.ack0);
            a1 += int'(bus.ack1);
            if ((bus.ack0 && bus.ack1) || (bus.gnt == 2'b11)) bad++;
        end
        chk("txn_ack0_cnt", 32'(a0), 32'(exp_g[0]));
        chk("txn_ack1_cnt", 32'(a1), 32'(exp_g[1]));
        chk("txn_exclusive", 32'(bad), 32'd0);
    endtask

    initial begin
        int flag;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.d0_0 = '0;
        bus.d0_1 = '0;
        bus.d1_0 = '0;
        bus.d1_1 = '0;
        bus.i2c_busy = 1'b0;
        step;
        step;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_start", 32'(bus.i2c_start), 32'd0);
        chk("rst_addr", 32'(bus.i2c_address), 32'd0);
        chk("rst_data", 32'({bus.i2c_data_0, bus.i2c_data_1}), 32'd0);
        chk("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        step;

        // Single transaction from requester 0
        bus.req0 = 1'b1;
        bus.addr0 = 7'h39;
        bus.d0_0 = 8'h41;
        bus.d0_1 = 8'h10;
        step;
        chk("t1_start_c1", 32'(bus.i2c_start), 32'd1);
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        chk("t1_out", 32'({1'b0, bus.i2c_address, bus.i2c_data_0, bus.i2c_data_1}), 32'h394110);
        bus.req0 = 1'b0;
        bus.addr0 = 7'h55;
        bus.d0_0 = 8'hAA;
        step;
        chk("t1_start_c2", 32'(bus.i2c_start), 32'd1);
        bus.i2c_busy = 1'b1;
        step;
        chk("t1_start_off", 32'(bus.i2c_start), 32'd0);
        flag = 0;
        repeat (19) begin
            step;
            if ({1'b0, bus.i2c_address, bus.i2c_data_0, bus.i2c_data_1} != 24'h394110) flag++;
            if (bus.ack0 || bus.ack1 || bus.i2c_start) flag++;
        end
        chk("t1_hold_stable", 32'(flag), 32'd0);
        bus.i2c_busy = 1'b0;
        step;
        chk("t1_ack0", 32'({bus.ack1, bus.ack0}), 32'h1);
        chk("t1_done_out", 32'({1'b0, bus.i2c_address, bus.i2c_data_0, bus.i2c_data_1}), 32'h394110);
        step;
        chk("t1_ack_pulse", 32'({bus.ack1, bus.ack0}), 32'h0);
        chk("t1_gnt_clear", 32'(bus.gnt), 32'h0);

        // Simultaneous requests, both held: 0,1,0,1
        do_reset;
        bus.addr0 = 7'h11;
        bus.addr1 = 7'h22;
        bus.d0_0 = 8'hA0;
        bus.d1_0 = 8'hB1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step;
        run_txn(2'b01, 7'h11, 8'hA0, 3);
        run_txn(2'b10, 7'h22, 8'hB1, 3);
        run_txn(2'b01, 7'h11, 8'hA0, 3);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        run_txn(2'b10, 7'h22, 8'hB1, 3);

        // External busy blocks grant; withdrawn req0 is ignored
        bus.i2c_busy = 1'b1;
        bus.req1 = 1'b1;
        flag = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req0 = (i == 1);
            step;
            if (bus.gnt != 2'b00 || bus.i2c_start) flag++;
        end
        chk("t3_no_grant_busy", 32'(flag), 32'd0);
        bus.i2c_busy = 1'b0;
        step;
        chk("t3_start_next", 32'(bus.i2c_start), 32'd1);
        chk("t3_gnt", 32'(bus.gnt), 32'h2);
        bus.req1 = 1'b0;
        run_txn(2'b10, 7'h22, 8'hB1, 2);

        // Reset during WAIT_DONE restores priority to requester 0
        bus.req0 = 1'b1;
        step;
        bus.req0 = 1'b0;
        run_txn(2'b01, 7'h11, 8'hA0, 2);
        bus.req1 = 1'b1;
        step;
        bus.req1 = 1'b0;
        chk("t4_gnt1", 32'(bus.gnt), 32'h2);
        bus.i2c_busy = 1'b1;
        step;
        chk("t4_wait", 32'(bus.i2c_start), 32'd0);
        rst = 1'b1;
        step;
        chk("t4_rst_start", 32'(bus.i2c_start), 32'd0);
        chk("t4_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("t4_rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        bus.i2c_busy = 1'b0;
        step;
        rst = 1'b0;
        flag = 0;
        repeat (3) begin
            step;
            if (bus.ack0 || bus.ack1) flag++;
        end
        chk("t4_no_ack", 32'(flag), 32'd0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step;
        chk("t4_prio0", 32'(bus.gnt), 32'h1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.i2c_busy = 1'b1;
        step;
        bus.i2c_busy = 1'b0;
        repeat (3) step;

`ifdef I2C_ARB_TIMEOUT_EN
        // Timeout in START with the master never going busy
        do_reset;
        bus.req0 = 1'b1;
        step;
        chk("t5_start", 32'(bus.i2c_start), 32'd1);
        bus.req0 = 1'b0;
        repeat (15) step;
        chk("t5_start_c16", 32'(bus.i2c_start), 32'd1);
        chk("t5_err_pre", 32'(bus.err), 32'd0);
        step;
        chk("t5_ack", 32'({bus.ack1, bus.ack0}), 32'h1);
        chk("t5_err_set", 32'(bus.err), 32'd1);
        step;
        chk("t5_ack_pulse", 32'({bus.ack1, bus.ack0}), 32'h0);
        chk("t5_gnt_clear", 32'(bus.gnt), 32'h0);
        repeat (5) step;
        chk("t5_err_sticky", 32'(bus.err), 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("t5_err_rst", 32'(bus.err), 32'd0);
`else
        // Without the timeout, START waits indefinitely
        bus.req0 = 1'b1;
        step;
        bus.req0 = 1'b0;
        flag = 0;
        repeat (40) begin
            step;
            if (!bus.i2c_start || bus.ack0 || bus.ack1) flag++;
        end
        chk("t5_wait_forever", 32'(flag), 32'd0);
        chk("t5_err_zero", 32'(bus.err), 32'd0);
        bus.i2c_busy = 1'b1;
        step;
        bus.i2c_busy = 1'b0;
        step;
        chk("t5_ack_late", 32'({bus.ack1, bus.ack0}), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum clk cycles allowed per START or WAIT_DONE phase.
REQ-002 SHALL have port clk  input  1  system clock (the 250 kHz I2C domain clock); all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0, req1  input  1 each  transaction request from requester 0 (HDMI config queue) and requester 1 (audio codec config queue).
REQ-005 SHALL have ports addr0, addr1  input  7 each  register address per requester.
REQ-006 SHALL have ports d0_0, d0_1, d1_0, d1_1  input  8 each  data bytes 0 and 1 for requester 0 and requester 1.
REQ-007 SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse per requester.
REQ-008 SHALL have port gnt  output  2  one-hot grant, or 2'b00 when no requester is granted.
REQ-009 SHALL have ports i2c_start (1), i2c_address (7), i2c_data_0 (8), i2c_data_1 (8), all outputs, that drive the shared I2C master.
REQ-010 SHALL have port i2c_busy  input  1  busy flag from the I2C master.
REQ-011 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-012 SHALL implement the states IDLE, START, WAIT_DONE and DONE.
REQ-013 In IDLE with i2c_busy=0 and at least one req high, SHALL grant one requester, latch its addr and data bytes into the i2c_* outputs, set gnt, and enter START.
REQ-014 SHALL NOT grant while i2c_busy=1 in IDLE.
REQ-015 SHALL arbitrate simultaneous requests round-robin; requester 0 has priority after reset, and the served requester becomes lowest priority after its DONE.
REQ-016 SHALL hold i2c_start=1 in START until i2c_busy is sampled 1, then enter WAIT_DONE with i2c_start=0 from that edge.
REQ-017 SHALL enter DONE on i2c_busy=0 in WAIT_DONE, pulse ack of the granted requester for exactly one cycle, clear gnt, and return to IDLE.
REQ-018 Latency: a req sampled high in IDLE SHALL produce i2c_start=1 in the following cycle.
REQ-019 SHALL hold i2c_address and i2c_data_* stable from grant through DONE; input changes after the grant SHALL be ignored.
REQ-020 A req dropped before grant SHALL be treated as withdrawn; a req dropped after grant SHALL NOT abort the transaction, and ack SHALL still pulse.
REQ-021 A requester holding req high across its ack SHALL be eligible again only after the other requester, if it is pending, is served.
REQ-022 ack0 and ack1 SHALL never be high in the same cycle, and gnt SHALL never be 2'b11.

Reset
REQ-023 rst SHALL force IDLE, gnt=0, ack0=ack1=0, i2c_start=0, i2c_address=0, i2c_data_*=0, err=0, and the round-robin pointer to requester 0.
REQ-024 rst asserted mid-transaction SHALL drop i2c_start on the same edge, and SHALL issue no ack for the aborted transaction.

Configuration
REQ-025 Macro I2C_ARB_TIMEOUT_EN defined: a cycle counter SHALL run in START and WAIT_DONE and clear on each state entry.
REQ-026 With I2C_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL set err, pulse ack of the granted requester, and return to IDLE via DONE.
REQ-027 Macro I2C_ARB_TIMEOUT_EN undefined: no counter SHALL exist, err SHALL be tied to 0, and START and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-028 A shared package i2c_arb_pkg SHALL hold the state enum, ADDR_W=7, DATA_W=8 and the REQ_N=2 constant.
REQ-029 The round-robin pick SHALL be a sub-module named rr_pick2 (inputs req[1:0] and last; output grant[1:0]).

Verification
REQ-030 Bench SHALL apply req0=1, addr0=7'h39, d0_0=8'h41, d0_1=8'h10 with i2c_busy rising 2 cycles after start, high 20 cycles -> i2c_start high 2 cycles, outputs 39/41/10 held stable, one ack0 pulse, gnt back to 00.
REQ-031 Bench SHALL apply req0 and req1 in the same cycle, both held -> order 0,1,0,1 with exactly one ack per transaction.
REQ-032 Bench SHALL change addr1 during WAIT_DONE -> i2c_address unchanged until DONE.
REQ-033 Bench SHALL hold i2c_busy=1 externally with req1=1 -> no grant until busy falls, then i2c_start next cycle.
REQ-034 Bench SHALL assert rst in WAIT_DONE -> i2c_start=0, gnt=0, no ack, and requester 0 wins the next simultaneous request.
REQ-035 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, bench SHALL keep i2c_busy=0 -> ack pulse and err=1 after 16 cycles in START, and err stays 1 until rst.
